// File: rtl/icache_fetch_unit.sv
// Direct-mapped instruction cache, LINES x 256-bit lines, with a two-state block refill FSM.
// Latency: a hit returns in the same cycle. A miss costs the RAM response time plus one cycle.
// Backpressure: stallreq_o holds the pipeline through a refill. Optional hit/miss counters are built under ICACHE_STATS_EN.
module icache_fetch_unit #(
    parameter int LINES = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  pc_i,
    input  logic         ce_i,
    input  logic         flush_i,
    output logic [31:0]  inst_o,
    output logic         stallreq_o,
    output logic         ram_en_o,
    output logic [29:0]  ram_addr_o,
    input  logic         ram_ready_i,
    input  logic [255:0] ram_block_i
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]  hit_cnt_o,
    output logic [31:0]  miss_cnt_o
`endif
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 27 - IDX_W;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t             state, state_nxt;
    logic [LINES-1:0]   valid;
    logic               drop;
    logic [26:0]        fill_addr;
    logic [TAG_W-1:0]   tag_arr  [LINES];
    logic [255:0]       data_arr [LINES];

    logic [2:0]         offset;
    logic [IDX_W-1:0]   index;
    logic [TAG_W-1:0]   tag;
    logic [IDX_W-1:0]   fill_index;
    logic [TAG_W-1:0]   fill_tag;
    logic [255:0]       line_dat;
    logic               hit;
    logic               unused_pc_lsb;

    assign offset        = pc_i[4:2];
    assign index         = pc_i[5 +: IDX_W];
    assign tag           = pc_i[31:5+IDX_W];
    assign fill_index    = fill_addr[IDX_W-1:0];
    assign fill_tag      = fill_addr[26:IDX_W];
    assign line_dat      = data_arr[index];
    assign hit           = valid[index] && (tag_arr[index] == tag);
    assign unused_pc_lsb = ^pc_i[1:0];

    // The FSM state resets asynchronously, so the refill request drops with rst and does not wait for a clock.
    assign ram_en_o   = (state == REFILL);
    assign ram_addr_o = ram_en_o ? {fill_addr, 3'b000} : 30'd0;

    always_comb begin
        state_nxt  = state;
        inst_o     = 32'd0;
        stallreq_o = 1'b0;
        case (state)
            IDLE: begin
                if (ce_i) begin
                    if (hit) begin
                        inst_o = line_dat[{offset, 5'b00000} +: 32];
                    end else begin
                        stallreq_o = 1'b1;
                        state_nxt  = REFILL;
                    end
                end
            end
            REFILL: begin
                stallreq_o = 1'b1;
                if (ram_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!rst) begin
            inst_o     = 32'd0;
            stallreq_o = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            valid     <= '0;
            drop      <= 1'b0;
            fill_addr <= 27'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == REFILL) begin
                fill_addr <= pc_i[31:5];
            end
            if (flush_i) begin
                valid <= '0;
            end
            if (state == REFILL) begin
                if (ram_ready_i) begin
                    // A flush seen at any point of the refill leaves the returning line invalid.
                    valid[fill_index] <= !(drop || flush_i);
                    drop              <= 1'b0;
                end else if (flush_i) begin
                    drop <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == REFILL && ram_ready_i) begin
            data_arr[fill_index] <= ram_block_i;
            tag_arr[fill_index]  <= fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_o  <= 32'd0;
            miss_cnt_o <= 32'd0;
        end else begin
            if (state == IDLE && ce_i && hit) begin
                hit_cnt_o <= hit_cnt_o + 32'd1;
            end
            if (state == IDLE && state_nxt == REFILL) begin
                miss_cnt_o <= miss_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/icache_fetch_unit.md
ICACHE_FETCH_UNIT -- requirements
Module: icache_fetch_unit

Interface
REQ-001 SHALL have parameter LINES, default 32, giving the number of direct-mapped lines (power of two); each line holds 8 words (256 bits).
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 pc_i  input  32  byte fetch address from the PC register; bits [1:0] are ignored.
REQ-006 ce_i  input  1  fetch enable from the PC register.
REQ-007 flush_i  input  1  invalidate all lines.
REQ-008 inst_o  output  32  fetched instruction to the IF/ID register.
REQ-009 stallreq_o  output  1  stall request to the pipeline controller.
REQ-010 ram_en_o  output  1  block read request to instruction memory.
REQ-011 ram_addr_o  output  30  block-aligned word address; bits [2:0] are always 0.
REQ-012 ram_ready_i  input  1  block valid on ram_block_i this cycle.
REQ-013 ram_block_i  input  256  refill block; word k occupies bits [32k+31:32k].

Function
REQ-014 SHALL decode pc_i as follows: offset = pc_i[4:2], index = pc_i[4+log2(LINES):5], tag = the remaining upper bits.
REQ-015 SHALL implement a two-state FSM with states IDLE and REFILL.
REQ-016 In IDLE with ce_i=1, a hit (valid[index] set and tag matches) SHALL drive inst_o with the selected word combinationally in the same cycle, with stallreq_o=0.
REQ-017 In IDLE with ce_i=1 and a miss, SHALL drive stallreq_o=1 combinationally, latch the block address pc_i[31:5], and enter REFILL at the next edge.
REQ-018 In REFILL, SHALL hold ram_en_o=1 and ram_addr_o={latched pc[31:5],3'b000} stable, and hold stallreq_o=1 and inst_o=0.
REQ-019 At the edge where ram_ready_i=1 in REFILL, SHALL write ram_block_i, the tag and the valid bit into the latched index, deassert ram_en_o, and return to IDLE.
REQ-020 Miss penalty SHALL be (RAM response cycles + 1); the cycle after the refill, the same pc_i SHALL hit.
REQ-021 With ce_i=0, SHALL drive inst_o=0 and stallreq_o=0, and SHALL start no refill.
REQ-022 A pc_i change during REFILL (branch redirect) SHALL NOT abort the refill; the latched address completes, and pc_i is re-looked-up in IDLE.
REQ-023 flush_i=1 in IDLE SHALL clear all valid bits at the next edge; stallreq_o is unaffected in that cycle.
REQ-024 flush_i=1 in REFILL SHALL clear all valid bits and mark the pending fill as dropped; the returning block is then written with valid=0.
REQ-025 When flush_i=1 coincides with ram_ready_i=1, the flush SHALL win: the line is left invalid.
REQ-026 ram_ready_i received in IDLE SHALL be ignored.

Reset
REQ-027 rst=0 SHALL immediately force: state IDLE, all valid bits 0, drop flag 0, ram_en_o=0, ram_addr_o=0, inst_o=0, stallreq_o=0.
REQ-028 Reset mid-REFILL SHALL abort the refill; ram_en_o SHALL drop asynchronously, and a later ram_ready_i SHALL be ignored.
REQ-029 Data and tag arrays SHALL NOT require reset.

Configuration
REQ-030 Macro ICACHE_STATS_EN, when defined, SHALL add outputs hit_cnt_o[31:0] and miss_cnt_o[31:0], both reset to 0.
REQ-031 hit_cnt_o SHALL increment each cycle with state IDLE, ce_i=1 and a hit; miss_cnt_o SHALL increment on each IDLE->REFILL transition.
REQ-032 Both counters SHALL wrap modulo 2^32 and SHALL NOT be cleared by flush_i.
REQ-033 Without ICACHE_STATS_EN, the counter ports and logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 Cold fetch: after reset, ce_i=1, pc_i=0x00000004 -> stallreq_o=1, ram_en_o=1, ram_addr_o=0; RAM returns the block after 3 cycles with word1=0x00A00093 -> next cycle inst_o=0x00A00093, stallreq_o=0.
REQ-035 Sequential hits: pc_i=0x00,0x04,...,0x1C after the fill -> 8 consecutive cycles with stallreq_o=0 and inst_o equal to block words 0..7; ram_en_o stays 0.
REQ-036 Conflict: with LINES=32, fill 0x00000000 then fetch 0x00000400 -> miss, ram_addr_o=0x00000100; a later fetch of 0x00000000 misses again.
REQ-037 Flush during refill: flush_i=1 for one cycle mid-REFILL -> the fill completes, and the next cycle the same pc_i misses again (stallreq_o=1).
REQ-038 Reset mid-refill: rst=0 while ram_en_o=1 -> ram_en_o=0 without waiting for a clock; after release, pc_i=0x4 misses.
REQ-039 With ICACHE_STATS_EN defined: scenario REQ-034 followed by REQ-035 -> miss_cnt_o=1 and hit_cnt_o=9.
